dac_stream_fifo: RTL



---
 rtl/dac_stream_fifo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dac_stream_fifo.sv
// DAC output stage: digital back-off gain with saturation, feeding a primed
// first-word-fall-through FIFO. Counts DAC underruns and flags clipping.
module dac_stream_fifo #(
    parameter int DATA_WIDTH  = 16,
    parameter int GAIN_WIDTH  = 16,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_i,
    input  logic [DATA_WIDTH-1:0] s_axis_q,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_i,
    output logic [DATA_WIDTH-1:0] m_axis_q,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    input  logic [GAIN_WIDTH-1:0] gain,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic [15:0]           underrun_cnt,
    output logic                  sat_flag,
    input  logic                  sat_clr
);

    localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int FRAC_W = GAIN_WIDTH - 2;
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int BEAT_W = 2 * DATA_WIDTH;

    localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(64'd1 << (FRAC_W - 1));
    localparam logic signed [PROD_W-1:0] SAT_MAX    = PROD_W'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
    localparam logic signed [PROD_W-1:0] SAT_MIN    = ~SAT_MAX;

    typedef enum logic [0:0] {
        ST_PRIME  = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                  state_reg;
    logic                    stage_valid_reg;
    logic [BEAT_W-1:0]       stage_data_reg;
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg;
    logic [ADDR_WIDTH-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [CNT_W-1:0]        count_next;
    logic [15:0]             underrun_cnt_reg;
    logic                    sat_flag_reg;

    logic [BEAT_W-1:0]       mem [DEPTH];
    logic [BEAT_W-1:0]       head_data;

    logic [BEAT_W-1:0]       scaled_data;
    logic [1:0]              lane_clip;
    logic [CNT_W:0]          occupancy;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    underrun;
    logic                    sat_set;

    // Lane 0 is I (upper half of a beat), lane 1 is Q.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0]     sample;
            logic signed [PROD_W-1:0]  sample_ext;
            logic signed [PROD_W-1:0]  gain_ext;
            logic signed [PROD_W-1:0]  product;
            logic signed [PROD_W-1:0]  rounded;
            logic signed [PROD_W-1:0]  shifted;
            logic [DATA_WIDTH-1:0]     result;
            logic                      clip;

            assign sample = (gi == 0) ? s_axis_i : s_axis_q;

            always_comb begin
                sample_ext = {{(PROD_W - DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
                gain_ext   = {{(PROD_W - GAIN_WIDTH){1'b0}}, gain};
                product    = sample_ext * gain_ext;
                rounded    = product + ROUND_HALF;
                shifted    = rounded >>> FRAC_W;
                clip       = 1'b0;
                result     = shifted[DATA_WIDTH-1:0];
                if (shifted > SAT_MAX) begin
                    clip   = 1'b1;
                    result = SAT_MAX[DATA_WIDTH-1:0];
                end else if (shifted < SAT_MIN) begin
                    clip   = 1'b1;
                    result = SAT_MIN[DATA_WIDTH-1:0];
                end
            end

            assign scaled_data[(1 - gi) * DATA_WIDTH +: DATA_WIDTH] = result;
            assign lane_clip[gi] = clip;
        end
    endgenerate

    // Counting the in-flight gain-stage beat guarantees it a FIFO slot.
    assign occupancy    = {1'b0, count_reg} + (CNT_W + 1)'(stage_valid_reg);
    assign s_axis_ready = rst_n & ~flush & (occupancy < (CNT_W + 1)'(DEPTH));
    assign accept       = s_axis_valid & s_axis_ready;

    assign m_axis_valid = (state_reg == ST_STREAM) && (count_reg != '0);
    assign push         = stage_valid_reg;
    assign pop          = m_axis_valid & m_axis_ready;
    assign underrun     = (state_reg == ST_STREAM) && m_axis_ready && (count_reg == '0);
    assign sat_set      = accept & (|lane_clip);
    assign count_next   = count_reg + CNT_W'(push) - CNT_W'(pop);

    assign head_data    = mem[rd_ptr_reg];
    assign m_axis_i     = (count_reg != '0) ? head_data[BEAT_W-1:DATA_WIDTH] : '0;
    assign m_axis_q     = (count_reg != '0) ? head_data[DATA_WIDTH-1:0] : '0;
    assign fill_level   = count_reg;
    assign underrun_cnt = underrun_cnt_reg;
    assign sat_flag     = sat_flag_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= stage_data_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_PRIME;
            stage_valid_reg  <= 1'b0;
            stage_data_reg   <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            underrun_cnt_reg <= '0;
            sat_flag_reg     <= 1'b0;
        end else begin
            if (underrun && (underrun_cnt_reg != 16'hFFFF)) begin
                underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
            end

            if (sat_set) begin
                sat_flag_reg <= 1'b1;
            end else if (sat_clr) begin
                sat_flag_reg <= 1'b0;
            end

            // Flush discards queued and in-flight data but keeps status.
            if (flush) begin
                state_reg       <= ST_PRIME;
                stage_valid_reg <= 1'b0;
                wr_ptr_reg      <= '0;
                rd_ptr_reg      <= '0;
                count_reg       <= '0;
            end else begin
                stage_valid_reg <= accept;
                if (accept) begin
                    stage_data_reg <= scaled_data;
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                count_reg <= count_next;

                case (state_reg)
                    ST_PRIME: begin
                        if (count_reg >= CNT_W'(PRIME_LEVEL)) begin
                            state_reg <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (underrun) begin
                            state_reg <= ST_PRIME;
                        end
                    end
                    default: state_reg <= ST_PRIME;
                endcase
            end
        end
    end

endmodule
